// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station slice.
//   XLEN           : datapath width of every stored operand / field
//   OP_W           : opcode width
//   DEF_*          : default sizing; DEF_TAG_W must equal the ROB tag width
//   op_e           : ALU-class opcodes handled by this station
package reservation_station_pkg;

   localparam int XLEN         = 32;
   localparam int OP_W         = 6;
   localparam int DEF_RS_SIZE  = 16;
   localparam int DEF_RS_IDX_W = 4;
   localparam int DEF_TAG_W    = 4;

   typedef enum logic [OP_W-1:0] {
      OP_LUI   = 6'd1,
      OP_AUIPC = 6'd2,
      OP_JAL   = 6'd3,
      OP_JALR  = 6'd4,
      OP_BEQ   = 6'd5,
      OP_BNE   = 6'd6,
      OP_BLT   = 6'd7,
      OP_BGE   = 6'd8,
      OP_BLTU  = 6'd9,
      OP_BGEU  = 6'd10,
      OP_ADDI  = 6'd19,
      OP_SLLI  = 6'd25,
      OP_ADD   = 6'd28,
      OP_SUB   = 6'd29
   } op_e;

endpackage

// File: rtl/reservation_station_picker.sv
// Combinational priority encoder for the reservation station.
//   busy        : per-entry occupied bits (registered)
//   ready       : per-entry ready-to-issue bits (registered state)
//   free_idx    : lowest-index non-busy entry, valid when free_found
//   ready_idx   : lowest-index ready entry, valid when ready_found
module reservation_station_picker
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE  = DEF_RS_SIZE,
   parameter int RS_IDX_W = DEF_RS_IDX_W
) (
   input  logic [RS_SIZE-1:0]  busy,
   input  logic [RS_SIZE-1:0]  ready,
   output logic [RS_IDX_W-1:0] free_idx,
   output logic                free_found,
   output logic [RS_IDX_W-1:0] ready_idx,
   output logic                ready_found
);

   // Scan from the top down so the last hit is the lowest index.
   always_comb begin
      free_idx    = '0;
      free_found  = 1'b0;
      ready_idx   = '0;
      ready_found = 1'b0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_found = 1'b1;
            free_idx   = RS_IDX_W'(i);
         end
         if (ready[i]) begin
            ready_found = 1'b1;
            ready_idx   = RS_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions.
// Holds dispatched instructions until both operands are known (snooping the
// ALU and LSB result broadcasts by ROB tag) and sends at most one ready entry
// per cycle to the ALU as a registered one-cycle new_calculate pulse.
//   clk_in, rst_in (async, active low), rdy_in (global enable), rollback
//   issue_*        : write port from the dispatcher
//   alu_/lsb_*     : result broadcasts (tag + value)
//   rs_full        : all entries busy, dispatcher must hold off
//   new_calculate, alu_* : registered operand bundle for the ALU
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE  = DEF_RS_SIZE,
   parameter int RS_IDX_W = DEF_RS_IDX_W,
   parameter int TAG_W    = DEF_TAG_W
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             rollback,
   input  logic             issue_valid,
   input  logic [OP_W-1:0]  issue_op,
   input  logic [XLEN-1:0]  issue_instruction,
   input  logic [XLEN-1:0]  issue_vj,
   input  logic [XLEN-1:0]  issue_vk,
   input  logic             issue_qj_busy,
   input  logic             issue_qk_busy,
   input  logic [TAG_W-1:0] issue_qj,
   input  logic [TAG_W-1:0] issue_qk,
   input  logic [XLEN-1:0]  issue_pc,
   input  logic [XLEN-1:0]  issue_imm,
   input  logic [TAG_W-1:0] issue_entry,
   input  logic             alu_broadcast,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [TAG_W-1:0] alu_entry,
   input  logic             lsb_broadcast,
   input  logic [XLEN-1:0]  lsb_result,
   input  logic [TAG_W-1:0] lsb_entry,
   output logic             rs_full,
   output logic             new_calculate,
   output logic [OP_W-1:0]  alu_op,
   output logic [XLEN-1:0]  alu_instruction,
   output logic [XLEN-1:0]  alu_vj,
   output logic [XLEN-1:0]  alu_vk,
   output logic [XLEN-1:0]  alu_pc,
   output logic [XLEN-1:0]  alu_imm,
   output logic [TAG_W-1:0] alu_entry_out
);

   logic [RS_SIZE-1:0]             busy, qj_busy, qk_busy, ready;
   logic [RS_SIZE-1:0][OP_W-1:0]   op_q;
   logic [RS_SIZE-1:0][XLEN-1:0]   instr_q, vj_q, vk_q, pc_q, imm_q;
   logic [RS_SIZE-1:0][TAG_W-1:0]  qj_q, qk_q, ent_q;

   logic [RS_SIZE-1:0]             snp_qj_busy, snp_qk_busy;
   logic [RS_SIZE-1:0][XLEN-1:0]   snp_vj, snp_vk;

   logic                in_qj_busy, in_qk_busy;
   logic [XLEN-1:0]     in_vj, in_vk;

   logic [RS_IDX_W-1:0] free_idx, ready_idx;
   logic                free_found, ready_found;

   assign ready   = busy & ~qj_busy & ~qk_busy;
   assign rs_full = &busy;

   reservation_station_picker #(
      .RS_SIZE  (RS_SIZE),
      .RS_IDX_W (RS_IDX_W)
   ) u_picker (
      .busy        (busy),
      .ready       (ready),
      .free_idx    (free_idx),
      .free_found  (free_found),
      .ready_idx   (ready_idx),
      .ready_found (ready_found)
   );

   // Forward a broadcast landing in the same cycle as the write; LSB wins a
   // (theoretically impossible) double match.
   always_comb begin
      in_qj_busy = issue_qj_busy;
      in_vj      = issue_vj;
      in_qk_busy = issue_qk_busy;
      in_vk      = issue_vk;
      if (issue_qj_busy) begin
         if (lsb_broadcast && lsb_entry == issue_qj) begin
            in_qj_busy = 1'b0;
            in_vj      = lsb_result;
         end else if (alu_broadcast && alu_entry == issue_qj) begin
            in_qj_busy = 1'b0;
            in_vj      = alu_result;
         end
      end
      if (issue_qk_busy) begin
         if (lsb_broadcast && lsb_entry == issue_qk) begin
            in_qk_busy = 1'b0;
            in_vk      = lsb_result;
         end else if (alu_broadcast && alu_entry == issue_qk) begin
            in_qk_busy = 1'b0;
            in_vk      = alu_result;
         end
      end
   end

   // Per-entry wake-up from the broadcast buses.
   always_comb begin
      snp_qj_busy = qj_busy;
      snp_qk_busy = qk_busy;
      snp_vj      = vj_q;
      snp_vk      = vk_q;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (busy[i] && qj_busy[i]) begin
            if (lsb_broadcast && lsb_entry == qj_q[i]) begin
               snp_qj_busy[i] = 1'b0;
               snp_vj[i]      = lsb_result;
            end else if (alu_broadcast && alu_entry == qj_q[i]) begin
               snp_qj_busy[i] = 1'b0;
               snp_vj[i]      = alu_result;
            end
         end
         if (busy[i] && qk_busy[i]) begin
            if (lsb_broadcast && lsb_entry == qk_q[i]) begin
               snp_qk_busy[i] = 1'b0;
               snp_vk[i]      = lsb_result;
            end else if (alu_broadcast && alu_entry == qk_q[i]) begin
               snp_qk_busy[i] = 1'b0;
               snp_vk[i]      = alu_result;
            end
         end
      end
   end

   // The free slot comes from registered busy bits, so it can never be the
   // entry being dispatched at this edge (a ready entry is always busy).
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy            <= '0;
         qj_busy         <= '0;
         qk_busy         <= '0;
         op_q            <= '0;
         instr_q         <= '0;
         vj_q            <= '0;
         vk_q            <= '0;
         pc_q            <= '0;
         imm_q           <= '0;
         qj_q            <= '0;
         qk_q            <= '0;
         ent_q           <= '0;
         new_calculate   <= 1'b0;
         alu_op          <= '0;
         alu_instruction <= '0;
         alu_vj          <= '0;
         alu_vk          <= '0;
         alu_pc          <= '0;
         alu_imm         <= '0;
         alu_entry_out   <= '0;
      end else if (rdy_in) begin
         if (rollback) begin
            busy          <= '0;
            new_calculate <= 1'b0;
         end else begin
            qj_busy       <= snp_qj_busy;
            qk_busy       <= snp_qk_busy;
            vj_q          <= snp_vj;
            vk_q          <= snp_vk;
            new_calculate <= ready_found;
            if (ready_found) begin
               alu_op          <= op_q[ready_idx];
               alu_instruction <= instr_q[ready_idx];
               alu_vj          <= vj_q[ready_idx];
               alu_vk          <= vk_q[ready_idx];
               alu_pc          <= pc_q[ready_idx];
               alu_imm         <= imm_q[ready_idx];
               alu_entry_out   <= ent_q[ready_idx];
               busy[ready_idx] <= 1'b0;
            end
            if (issue_valid && free_found) begin
               busy[free_idx]    <= 1'b1;
               op_q[free_idx]    <= issue_op;
               instr_q[free_idx] <= issue_instruction;
               pc_q[free_idx]    <= issue_pc;
               imm_q[free_idx]   <= issue_imm;
               ent_q[free_idx]   <= issue_entry;
               qj_q[free_idx]    <= issue_qj;
               qk_q[free_idx]    <= issue_qk;
               qj_busy[free_idx] <= in_qj_busy;
               qk_busy[free_idx] <= in_qk_busy;
               vj_q[free_idx]    <= in_vj;
               vk_q[free_idx]    <= in_vk;
            end
         end
      end else begin
         new_calculate <= 1'b0;
      end
   end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Holds decoded ALU-class instructions (branches, JAL/JALR, I/R/U arithmetic) between dispatch and execution.
- Tracks operand dependencies by ROB tag and snoops the ALU and LSB result broadcasts.
- Each cycle, issues at most one fully-ready entry to the ALU as a registered one-cycle `new_calculate` pulse with all operand fields.
- Sits directly upstream of the ALU and downstream of the dispatcher.

Parameters:
- RS_SIZE, 16, number of entries; power of two, at least 2.
- RS_IDX_W, 4, log2(RS_SIZE); entry index width.
- TAG_W, 4, ROB tag width; must match the width of `ENTRY_RANGE.

Ports:
- clk_in input 1: single clock.
- rst_in input 1: asynchronous, active-low reset.
- rdy_in input 1: global enable; low freezes the block.
- rollback input 1: ROB misprediction flush.
- issue_valid input 1: dispatcher writes one instruction this cycle.
- issue_op input 6: opcode from operaType.
- issue_instruction input 32: raw instruction word (needed for shamt).
- issue_vj, issue_vk input 32: operand values, valid when the matching busy bit is 0.
- issue_qj_busy, issue_qk_busy input 1: operand still pending.
- issue_qj, issue_qk input TAG_W: producer ROB tag.
- issue_pc, issue_imm input 32: PC and immediate.
- issue_entry input TAG_W: destination ROB tag.
- alu_broadcast input 1, alu_result input 32, alu_entry input TAG_W: ALU completion.
- lsb_broadcast input 1, lsb_result input 32, lsb_entry input TAG_W: load completion.
- rs_full output 1: no free entry; dispatcher must not issue.
- new_calculate output 1: one-cycle pulse, ALU operands valid.
- alu_op output 6, alu_instruction output 32, alu_vj output 32, alu_vk output 32, alu_pc output 32, alu_imm output 32, alu_entry_out output TAG_W: registered ALU inputs.

Behaviour:
- Reset (rst_in low, asynchronous):
  - All entry busy bits cleared.
  - All registered outputs are 0.
  - rs_full is 0.
- Entry state: busy, op, instruction, vj, vk, qj_busy, qk_busy, qj, qk, pc, imm, entry.
- rdy_in low: no state changes; new_calculate = 0. Broadcasts never occur while rdy_in is low.
- rs_full is combinational from registered busy bits and is 1 only when all RS_SIZE entries are busy.
  - A dispatch in the same cycle does not clear rs_full until the next cycle.
  - issue_valid while rs_full = 1 is illegal; the entry is dropped and a bench assertion flags it.
- Issue (write):
  - The instruction is written into the lowest-index free entry.
  - Same-cycle forwarding: if a pending operand's tag equals alu_entry while alu_broadcast = 1, capture alu_result and clear its busy bit. Same for lsb_entry/lsb_result.
  - If both broadcasts match, LSB takes priority; the ROB guarantees tags are unique, so this case does not occur in practice.
- Snoop: every busy entry compares its pending qj/qk against both broadcasts each cycle and captures the value on a match.
- Ready: busy && !qj_busy && !qk_busy, evaluated on registered state.
  - An entry written or woken in cycle t is eligible in cycle t+1 at the earliest.
  - Issue-to-ALU latency is therefore 2 cycles minimum, with new_calculate rising at edge t+2.
- Dispatch (read):
  - The lowest-index ready entry is selected.
  - Its fields are registered onto the alu_* outputs, new_calculate = 1 for exactly one cycle, and the entry's busy bit is cleared at the same edge.
  - With no ready entry: new_calculate = 0 and the alu_* outputs hold their previous values.
- Simultaneous issue and dispatch are both allowed. The freed entry may be reused no earlier than the next cycle (the free-pick uses registered busy bits).
- Rollback = 1:
  - At the next edge all busy bits clear and new_calculate = 0.
  - A same-cycle issue and dispatch are discarded.
- Widths: every stored value is 32 bits and tags are TAG_W; there is no arithmetic in the block.

Decomposition:
- operaType.v gains RS_SIZE, RS_IDX_RANGE and a note that `ENTRY_RANGE width == TAG_W. Opcode defines are already shared there.
- One sub-module, rs_picker: purely combinational priority encoder.
  - Inputs: busy[RS_SIZE], ready[RS_SIZE].
  - Outputs: free_idx, free_found, ready_idx, ready_found.

Test Plan:
- Reset behaviour: reset, then ADDI with vj=5, imm=3, both operands ready, entry=2 -> new_calculate pulses exactly 2 cycles after issue with alu_vj=5, alu_imm=3, alu_entry_out=2.
- Broadcast wake-up: issue ADD with qj=7 busy, vk=10 -> no dispatch; drive alu_broadcast with entry 7, result 0x20 -> next cycle dispatches alu_vj=0x20, alu_vk=10.
- Same-cycle forwarding at issue: issue SUB with qk=3 busy while lsb_broadcast carries entry 3, result 0xFFFF_FFFF -> stored as ready, dispatched 2 cycles later with alu_vk=0xFFFF_FFFF.
- Full and priority: fill 16 entries all blocked on tag 9 -> rs_full=1. Broadcast tag 9 -> entries 0..15 dispatch in index order over 16 consecutive cycles; rs_full drops the cycle after the first dispatch.
- Rollback: 5 entries busy, 2 of them ready, assert rollback together with issue_valid -> next cycle rs_full=0, no new_calculate, and no stale dispatch in the following 4 cycles.
- Freeze and async reset: hold rdy_in=0 with a ready entry -> new_calculate stays 0 and the entry remains. Drop rst_in mid-dispatch -> outputs go to 0 immediately, without waiting for a clock edge.
